bit_serializer: RTL and testbench

Parallel-to-serial front end for the Moore sequence detector: accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per enabled clock on a single-bit stream. The stream drives the detector's `w` input directly. It runs on the detector's clock and reset. `w_valid` tells downstream logic when the stream carries real data rather than idle fill.

---
 rtl/serial_pkg.sv | 26 ++
 rtl/bit_serializer.sv | 102 ++++++++++
 tb/tb_bit_serializer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial front end and the Moore sequence
// detector it feeds.
//   ser_state_t : serializer FSM encodings
//   det_state_t : detector FSM encodings, kept here so both stages agree
//   cnt_width() : bit-counter width for a given word width
package serial_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_t;

  typedef enum logic [2:0] {
    DET_S0 = 3'b000,
    DET_S1 = 3'b001,
    DET_S2 = 3'b010,
    DET_S3 = 3'b011,
    DET_S4 = 3'b100,
    DET_S5 = 3'b101
  } det_state_t;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the Moore sequence detector.
// Takes WIDTH-bit words over valid/ready and emits one bit per en=1 edge on w,
// which drives the detector's w input directly (same clk and clr).
//
// Ports
//   clk        clock, rising edge
//   clr        synchronous active-low reset
//   en         bit strobe; the stream advances only on en=1 edges
//   din        parallel word
//   din_valid  din holds a word to send
//   din_ready  word accepted this cycle (combinational, no path from din_valid)
//   w          serial bit, IDLE_BIT when no word is in flight
//   w_valid    w carries a data bit
//   busy       a word is in flight
//
// state   | meaning
// S_IDLE  | no word loaded, w shows IDLE_BIT
// S_SHIFT | word loaded, w shows the current bit
module bit_serializer
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             w,
  output logic             w_valid,
  output logic             busy
);

  localparam int unsigned    CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  ser_state_t       state;
  ser_state_t       state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             accept;
  logic             advance;

  assign last = (cnt == LAST_CNT);

  // In SHIFT a new word is only taken as the last bit leaves, which gives
  // gap-free back-to-back streaming without a second holding register.
  assign din_ready = clr & ((state == S_IDLE) | ((state == S_SHIFT) & last & en));
  assign accept    = din_valid & din_ready;
  assign advance   = (state == S_SHIFT) & en & ~last;

  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (en && last) state_nxt = accept ? S_SHIFT : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      shreg <= din;
      cnt   <= '0;
    end else if (advance) begin
      // Move the next bit into the output position, zero fill behind it.
      shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
      cnt   <= cnt + CW'(1);
    end
  end

  always_comb begin
    w       = IDLE_BIT;
    w_valid = 1'b0;
    busy    = 1'b0;
    if (state == S_SHIFT) begin
      w       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
      w_valid = 1'b1;
      busy    = 1'b1;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       clr;
  logic       en;
  logic [7:0] din;
  logic       din_valid;

  logic rdy_m, w_m, wv_m, bsy_m;
  logic rdy_l, w_l, wv_l, bsy_l;

  int vectors    = 0;
  int miscompares = 0;
  bit mon_on     = 1'b0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .clr(clr), .en(en), .din(din), .din_valid(din_valid),
    .din_ready(rdy_m), .w(w_m), .w_valid(wv_m), .busy(bsy_m)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
    .clk(clk), .clr(clr), .en(en), .din(din), .din_valid(din_valid),
    .din_ready(rdy_l), .w(w_l), .w_valid(wv_l), .busy(bsy_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: bits in transmit order, pushed on accept, popped on each
  // en=1 edge while a word is in flight.
  bit qm[$];
  bit ql[$];
  bit m_busy = 1'b0;
  int m_left = 0;

  function automatic bit model_ready();
    return clr && (!m_busy || (m_left == 1 && en));
  endfunction

  always @(posedge clk) begin
    bit r;
    if (!clr) begin
      qm.delete();
      ql.delete();
      m_busy = 1'b0;
      m_left = 0;
    end else begin
      r = model_ready();
      if (m_busy && en) begin
        if (qm.size() > 0) void'(qm.pop_front());
        if (ql.size() > 0) void'(ql.pop_front());
        m_left--;
        if (m_left == 0) m_busy = 1'b0;
      end
      if (din_valid && r) begin
        for (int i = 7; i >= 0; i--) qm.push_back(din[i]);
        for (int i = 0; i <= 7; i++) ql.push_back(din[i]);
        m_busy = 1'b1;
        m_left = 8;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      chk("ready_m", 32'(rdy_m), 32'(model_ready()));
      chk("ready_l", 32'(rdy_l), 32'(model_ready()));
      chk("busy_m", 32'(bsy_m), 32'(m_busy));
      chk("wvalid_l", 32'(wv_l), 32'(m_busy));
      if (m_busy) begin
        if (qm.size() == 0 || ql.size() == 0) chk("sb_empty", 32'd1, 32'd0);
        else begin
          chk("w_msb", 32'(w_m), 32'(qm[0]));
          chk("w_lsb", 32'(w_l), 32'(ql[0]));
        end
      end else begin
        chk("w_idle_m", 32'(w_m), 32'd0);
        chk("w_idle_l", 32'(w_l), 32'd0);
      end
    end
  end

  typedef struct {
    logic [7:0] din;
    int         period;
    int         exp_busy;
    logic [7:0] lsb_seq;   // LSB-first stream, first bit in bit 7
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [7:0]  capm, capl;
    logic [15:0] cap16;
    int nb, nrdy, nval;
    bit done;

    tbl[0] = '{din: 8'hB4, period: 1, exp_busy: 8,  lsb_seq: 8'h2D};
    tbl[1] = '{din: 8'h81, period: 3, exp_busy: 24, lsb_seq: 8'h81};
    tbl[2] = '{din: 8'h01, period: 1, exp_busy: 8,  lsb_seq: 8'h80};
    tbl[3] = '{din: 8'hAA, period: 2, exp_busy: 16, lsb_seq: 8'h55};
    tbl[4] = '{din: 8'h3C, period: 1, exp_busy: 8,  lsb_seq: 8'h3C};

    // Reset held with a pending word
    clr = 1'b0; en = 1'b1; din = 8'h5A; din_valid = 1'b1;
    repeat (3) begin
      @(posedge clk);
      mon_on = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(rdy_m), 32'd0);
      chk("rst_w", 32'(w_m), 32'd0);
      chk("rst_wvalid", 32'(wv_m), 32'd0);
      chk("rst_busy", 32'(bsy_l), 32'd0);
    end
    @(posedge clk); #1;
    clr = 1'b1; din_valid = 1'b0; en = 1'b0;

    // Single words at various strobe rates
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      din = tbl[i].din; din_valid = 1'b1; en = 1'b0;
      capm = '0; capl = '0; nb = 0; done = 1'b0;
      for (int k = 1; k <= 60 && !done; k++) begin
        @(posedge clk); #1;
        din_valid = 1'b0;
        din = 8'($urandom);
        en = ((k % tbl[i].period) == 0);
        @(negedge clk);
        if (bsy_m) begin
          nb++;
          if (en) begin
            capm = {capm[6:0], w_m};
            capl = {capl[6:0], w_l};
          end
        end else done = 1'b1;
      end
      chk("vec_busy_cycles", 32'(nb), 32'(tbl[i].exp_busy));
      chk("vec_msb_stream", 32'(capm), 32'(tbl[i].din));
      chk("vec_lsb_stream", 32'(capl), 32'(tbl[i].lsb_seq));
    end

    // Back-to-back FF then 00
    @(posedge clk); #1;
    din = 8'hFF; din_valid = 1'b1; en = 1'b1;
    cap16 = '0; nrdy = 0; nval = 0;
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      if (k < 16 && rdy_m) nrdy++;
      if (k >= 1 && wv_m) begin
        nval++;
        cap16 = {cap16[14:0], w_m};
      end
      @(posedge clk); #1;
      if (k == 0) din = 8'h00;
      if (k == 8) din_valid = 1'b0;
    end
    chk("b2b_ready_count", 32'(nrdy), 32'd2);
    chk("b2b_valid_bits", 32'(nval), 32'd16);
    chk("b2b_stream", 32'(cap16), 32'h0000FF00);
    @(negedge clk);
    chk("b2b_idle_after", 32'(wv_m), 32'd0);

    // Mid-word reset, then immediate restart
    @(posedge clk); #1;
    din = 8'hAA; din_valid = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("midrst_ready_forced", 32'(rdy_m), 32'd0);
    @(posedge clk); #1;
    clr = 1'b1; din = 8'hC3; din_valid = 1'b1;
    @(negedge clk);
    chk("midrst_w", 32'(w_m), 32'd0);
    chk("midrst_wvalid", 32'(wv_m), 32'd0);
    chk("midrst_ready", 32'(rdy_m), 32'd1);
    @(posedge clk); #1;
    din_valid = 1'b0;
    @(negedge clk);
    chk("restart_wvalid", 32'(wv_m), 32'd1);
    chk("restart_w_msb", 32'(w_m), 32'd1);
    chk("restart_w_lsb", 32'(w_l), 32'd1);

    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("final_idle", 32'(bsy_m), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
